// File: rtl/ppcpu_mem_arbiter.sv
// Shares one unified memory between IF fetches and MEM loads/stores; ARB_RR_EN selects round-robin over fixed D-over-I priority.
// Latency: Done pulses LAT+1 cycles after a Req is sampled in IDLE; one access per LAT+2 cycles.
// Backpressure: a pending Req is held until its Done, and Stall stays high meanwhile.
module ppcpu_mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          I_Req,
  input  logic [AW-1:0] I_Addr,
  output logic [DW-1:0] I_Rdata,
  output logic          I_Done,
  input  logic          D_Req,
  input  logic          D_We,
  input  logic [AW-1:0] D_Addr,
  input  logic [DW-1:0] D_Wdata,
  output logic [DW-1:0] D_Rdata,
  output logic          D_Done,
  output logic          Mem_En,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_Wdata,
  input  logic [DW-1:0] Mem_Rdata,
  output logic          Stall,
  output logic          Busy
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt_d;
  logic       pick_d;

`ifdef ARB_RR_EN
  // last_d = 1 when D won the previous grant; cleared means I was last.
  logic last_d;

  always_comb pick_d = D_Req & (~I_Req | ~last_d);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      last_d <= 1'b0;
    end else if (state == IDLE && (I_Req || D_Req)) begin
      last_d <= pick_d;
    end
  end
`else
  always_comb pick_d = D_Req;
`endif

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_d     <= 1'b0;
      Mem_En    <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_Wdata <= '0;
      I_Rdata   <= '0;
      D_Rdata   <= '0;
      I_Done    <= 1'b0;
      D_Done    <= 1'b0;
    end else begin
      I_Done <= 1'b0;
      D_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (I_Req || D_Req) begin
            gnt_d     <= pick_d;
            Mem_En    <= 1'b1;
            Mem_We    <= pick_d & D_We;
            Mem_Addr  <= pick_d ? D_Addr : I_Addr;
            Mem_Wdata <= pick_d ? D_Wdata : '0;
            cnt       <= CNT_INIT;
            state     <= ACC;
          end
        end
        ACC: begin
          if (cnt == 4'd0) begin
            Mem_En <= 1'b0;
            Mem_We <= 1'b0;
            // Mem_Rdata is only valid now, in the last cycle of the window.
            if (gnt_d) begin
              D_Done <= 1'b1;
              if (!Mem_We) D_Rdata <= Mem_Rdata;
            end else begin
              I_Done  <= 1'b1;
              I_Rdata <= Mem_Rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy  = (state != IDLE);
  assign Stall = (I_Req & ~I_Done) | (D_Req & ~D_Done);

endmodule

// File: tb/tb_ppcpu_mem_arbiter.sv
// Randomized bench for ppcpu_mem_arbiter checked against a transaction-timeline reference model.
module tb_ppcpu_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          Clk = 1'b0;
  logic          Clrn;
  logic          I_Req, D_Req, D_We;
  logic [AW-1:0] I_Addr, D_Addr;
  logic [DW-1:0] D_Wdata, Mem_Rdata;
  logic [DW-1:0] I_Rdata, D_Rdata, Mem_Wdata;
  logic [AW-1:0] Mem_Addr;
  logic          I_Done, D_Done, Mem_En, Mem_We, Stall, Busy;

  // second instance for the LAT=1 fetch stream
  logic          i_req_l1;
  logic [AW-1:0] i_addr_l1, mem_addr_l1;
  logic [DW-1:0] i_rdata_l1, d_rdata_l1, mem_wdata_l1, mem_rdata_l1;
  logic          i_done_l1, d_done_l1, mem_en_l1, mem_we_l1, stall_l1, busy_l1;
  logic          d_req_l1, d_we_l1;
  logic [AW-1:0] d_addr_l1;
  logic [DW-1:0] d_wdata_l1;

  always #5 Clk = ~Clk;

  ppcpu_mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) u_dut (
    .Clk(Clk), .Clrn(Clrn),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Rdata(I_Rdata), .I_Done(I_Done),
    .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_Wdata(D_Wdata),
    .D_Rdata(D_Rdata), .D_Done(D_Done),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Stall(Stall), .Busy(Busy)
  );

  ppcpu_mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut_l1 (
    .Clk(Clk), .Clrn(Clrn),
    .I_Req(i_req_l1), .I_Addr(i_addr_l1), .I_Rdata(i_rdata_l1), .I_Done(i_done_l1),
    .D_Req(d_req_l1), .D_We(d_we_l1), .D_Addr(d_addr_l1), .D_Wdata(d_wdata_l1),
    .D_Rdata(d_rdata_l1), .D_Done(d_done_l1),
    .Mem_En(mem_en_l1), .Mem_We(mem_we_l1), .Mem_Addr(mem_addr_l1), .Mem_Wdata(mem_wdata_l1),
    .Mem_Rdata(mem_rdata_l1), .Stall(stall_l1), .Busy(busy_l1)
  );

  assign mem_rdata_l1 = mem_en_l1 ? (mem_addr_l1 ^ 32'h5A5A_0000) : 32'h0;

  // Memory environment: data is presented only in the last cycle of the enable window.
  logic [DW-1:0] phys_mem [64];
  int            mem_cnt;

  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn)       mem_cnt <= 0;
    else if (Mem_En) mem_cnt <= mem_cnt + 1;
    else             mem_cnt <= 0;
  end

  assign Mem_Rdata = (Mem_En && mem_cnt == LAT - 1) ? phys_mem[Mem_Addr[7:2]] : 32'hBAD0_BAD0;

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  int            cyc;
  bit            act_vld, act_d, act_we, last_d;
  int            act_g;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_wdata, act_rd;
  logic [DW-1:0] exp_i_rdata, exp_d_rdata;
  bit            seen_i_done, seen_d_done;
  int            n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [5:0] idx;
    idx = 6'($urandom_range(0, 63));
    return {24'h0, idx, 2'b00};
  endfunction

  // One clock cycle: check at the falling edge, then return just after the rising edge.
  task automatic tick();
    bit idle_now, e_id, e_dd, e_en;
    @(negedge Clk);
    idle_now = !act_vld;
    e_id = act_vld && !act_d && (cyc == act_g + LAT + 1);
    e_dd = act_vld &&  act_d && (cyc == act_g + LAT + 1);
    e_en = act_vld && (cyc > act_g) && (cyc <= act_g + LAT);
    if (e_id) exp_i_rdata = act_rd;
    if (e_dd && !act_we) exp_d_rdata = act_rd;

    chk("i_done", I_Done, e_id);
    chk("d_done", D_Done, e_dd);
    chk("mem_en", Mem_En, e_en);
    chk("busy", Busy, !idle_now);
    chk("stall", Stall, (I_Req && !e_id) || (D_Req && !e_dd));
    chk("i_rdata", I_Rdata, exp_i_rdata);
    chk("d_rdata", D_Rdata, exp_d_rdata);
    if (e_en) begin
      chk("mem_we", Mem_We, act_we);
      chk("mem_addr", Mem_Addr, act_addr);
      if (act_we) chk("mem_wdata", Mem_Wdata, act_wdata);
    end else begin
      chk("mem_we_idle", Mem_We, 1'b0);
    end

    if (Mem_En && Mem_We && mem_cnt == LAT - 1) phys_mem[Mem_Addr[7:2]] = Mem_Wdata;

    seen_i_done = e_id;
    seen_d_done = e_dd;
    if (e_id || e_dd) act_vld = 1'b0;

    if (idle_now && (I_Req || D_Req)) begin
`ifdef ARB_RR_EN
      act_d = D_Req && (!I_Req || !last_d);
`else
      act_d = D_Req;
`endif
      last_d    = act_d;
      act_vld   = 1'b1;
      act_g     = cyc;
      act_we    = act_d && D_We;
      act_addr  = act_d ? D_Addr : I_Addr;
      act_wdata = D_Wdata;
      if (act_we) ref_mem[act_addr[7:2]] = D_Wdata;
      else        act_rd = ref_mem[act_addr[7:2]];
    end
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  // Run until both requesters are served and the arbiter is idle; each drops Req after its Done.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((I_Req || D_Req || act_vld) && n < budget) begin
      tick();
      n++;
      if (seen_i_done) I_Req = 1'b0;
      if (seen_d_done) D_Req = 1'b0;
    end
    chk("drain_timeout", {31'b0, (I_Req || D_Req || act_vld)}, 32'b0);
  endtask

  initial begin
    int last_c, ndone;
    bit dn;
    Clrn = 1'b0;
    I_Req = 0; D_Req = 0; D_We = 0; I_Addr = '0; D_Addr = '0; D_Wdata = '0;
    i_req_l1 = 0; i_addr_l1 = '0; d_req_l1 = 0; d_we_l1 = 0; d_addr_l1 = '0; d_wdata_l1 = '0;
    n_cmp = 0; n_err = 0; cyc = 0;
    act_vld = 0; act_d = 0; act_we = 0; last_d = 0; act_g = 0;
    act_addr = '0; act_wdata = '0; act_rd = '0;
    exp_i_rdata = '0; exp_d_rdata = '0; seen_i_done = 0; seen_d_done = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]  = $urandom;
      phys_mem[i] = ref_mem[i];
    end
    ref_mem[4]  = 32'h8C01_0004;
    phys_mem[4] = 32'h8C01_0004;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_i_rdata", I_Rdata, 0);
    chk("rst_d_rdata", D_Rdata, 0);
    chk("rst_i_done", I_Done, 0);
    chk("rst_d_done", D_Done, 0);
    chk("rst_mem_en", Mem_En, 0);
    chk("rst_mem_we", Mem_We, 0);
    chk("rst_mem_addr", Mem_Addr, 0);
    chk("rst_mem_wdata", Mem_Wdata, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_stall", Stall, 0);
    Clrn = 1'b1;

    // single fetch, store, load-back, then two conflicts
    I_Req = 1; I_Addr = 32'h10;
    drain(20);
    D_Req = 1; D_We = 1; D_Addr = 32'h40; D_Wdata = 32'hDEAD_BEEF;
    drain(20);
    D_Req = 1; D_We = 0; D_Addr = 32'h40;
    drain(20);
    I_Req = 1; I_Addr = 32'h20; D_Req = 1; D_We = 0; D_Addr = 32'h24;
    drain(30);
    D_Req = 1; D_We = 1; D_Addr = 32'h28; D_Wdata = 32'h1234_5678;
    drain(20);
    I_Req = 1; I_Addr = 32'h28; D_Req = 1; D_We = 0; D_Addr = 32'h2C;
    drain(30);

    // randomized traffic from both requesters
    repeat (800) begin
      tick();
      if (I_Req && seen_i_done) I_Req = 1'b0;
      if (D_Req && seen_d_done) D_Req = 1'b0;
      if (!I_Req && $urandom_range(0, 2) == 0) begin
        I_Req = 1'b1; I_Addr = rand_addr();
      end
      if (!D_Req && $urandom_range(0, 2) == 0) begin
        D_Req = 1'b1; D_We = 1'($urandom_range(0, 1)); D_Addr = rand_addr(); D_Wdata = $urandom;
      end
    end
    drain(40);

    // reset during the second ACC cycle of a fetch
    I_Req = 1; I_Addr = 32'h10;
    tick();
    tick();
    #2 Clrn = 1'b0;
    #1;
    chk("abort_mem_en", Mem_En, 0);
    chk("abort_mem_we", Mem_We, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_i_done", I_Done, 0);
    chk("abort_i_rdata", I_Rdata, 0);
    chk("abort_d_rdata", D_Rdata, 0);
    chk("abort_mem_addr", Mem_Addr, 0);
    act_vld = 0; last_d = 0; exp_i_rdata = '0; exp_d_rdata = '0;
    I_Req = 1'b0;
    @(posedge Clk);
    #1 Clrn = 1'b1;
    repeat (6) tick();

    // LAT=1: four back-to-back fetches, Done every 3 cycles
    i_req_l1 = 1'b1; i_addr_l1 = 32'h100;
    last_c = -1; ndone = 0;
    for (int c = 0; c < 20 && ndone < 4; c++) begin
      @(negedge Clk);
      dn = i_done_l1;
      if (dn) begin
        chk("l1_gap", 32'(c - last_c), 32'd3);
        chk("l1_rdata", i_rdata_l1, i_addr_l1 ^ 32'h5A5A_0000);
        chk("l1_stall_done", stall_l1, 0);
        ndone++;
        last_c = c;
      end else if (c == 1) begin
        chk("l1_mem_en", mem_en_l1, 1);
      end
      @(posedge Clk);
      #1;
      if (dn) begin
        if (ndone == 4) i_req_l1 = 1'b0;
        else            i_addr_l1 = i_addr_l1 + 32'h4;
      end
    end
    chk("l1_count", ndone, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
